shift_rows_pipe: RTL
====================

# shift_rows_pipe

Parametrised, pipelined AES ShiftRows / InvShiftRows unit for the execute stage of the SIMD processor. It processes `LANES` independent 128-bit states per beat and selects forward or inverse permutation per beat. It is an elastic valid/ready pipeline of `PIPE_DEPTH` register stages, so it can sit between the SubBytes and MixColumns units without global stall logic.

## Interface
- `LANES`, 1: number of 128-bit AES states per beat (1..8).
- `PIPE_DEPTH`, 2: number of register stages (1..4).
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: input beat present.
- `in_ready` output 1: unit accepts the beat this cycle.
- `in_inverse` input 1: 0 = ShiftRows, 1 = InvShiftRows, sampled with the beat.
- `in_state` input `LANES*128`: lane l at `[128*l +: 128]`.
- `out_valid` output 1: output beat present.
- `out_ready` input 1: downstream accepts.
- `out_inverse` output 1: mode travelling with the beat.
- `out_state` output `LANES*128`: permuted states, same lane mapping.
- `occupancy` output `$clog2(PIPE_DEPTH+1)`: beats currently held.

## Operation
- Byte order inside a lane: byte i = `lane[127-8i -: 8]`, column-major, i = r + 4c (r = row, c = column).
- Forward mode: out[r+4c] = in[r + 4*((c+r) mod 4)]. Row 0 is unchanged; row r rotates left by r.
- Inverse mode: out[r+4c] = in[r + 4*((c−r) mod 4)].
- Permutation is combinational on the input side; stage 0 registers the permuted data plus mode. Later stages are pure pass-through registers.
- All lanes use the same `in_inverse` for a given beat. Lanes never mix bytes.
- Handshake: a transfer occurs when valid && ready on either port.
  - Stage k loads when it is empty or stage k+1 (or the output, for the last stage) advances.
  - `in_ready` = stage 0 empty or stage 0 advancing. It is combinational from `out_ready` through the chain.
  - Bubbles collapse.
- Once `out_valid` is high, `out_state` and `out_inverse` are held stable until `out_ready`.
- `occupancy` increments on an input transfer alone, decrements on an output transfer alone, and is unchanged when both occur.
- Reset mid-operation discards all in-flight beats. No partial beat is ever emitted.

## Timing
- Reset values: `out_valid`=0, `out_state`=0, `out_inverse`=0, `occupancy`=0, all stage valid bits 0.
- `in_ready` becomes 1 in the first cycle after `rst` deasserts.
- Latency: a beat accepted at edge N appears on `out_valid` after edge N+`PIPE_DEPTH−1`, i.e. it is visible `PIPE_DEPTH` cycles after acceptance with `out_ready`=1 throughout.
- Throughput: 1 beat/cycle with `out_ready` held high.
- Full pipeline (`occupancy`=`PIPE_DEPTH`) with `out_ready`=0 forces `in_ready`=0.
- Full pipeline with `out_ready`=1 keeps `in_ready`=1: simultaneous in/out transfer, and occupancy is unchanged.
- Empty pipeline: `out_valid`=0, and `out_state` holds its last value (not re-zeroed).
- Mode changes between consecutive beats need no gap cycle.

## Structure
- Package `aes_pkg`:
  - `STATE_W`=128, `BYTE_W`=8
  - `typedef logic [7:0] aes_byte_t`
  - `typedef aes_byte_t aes_state_t [16]`
  - functions `state_to_bytes` and `bytes_to_state` implementing the byte order above
  - enum `sr_mode_e {SR_FWD, SR_INV}`
- Sub-module `shift_rows_perm`: combinational, one 128-bit lane plus mode in, permuted lane out. Instantiated `LANES` times by generate.
- Pipeline stages are a generate loop of valid/data/mode registers in the top module. No separate FIFO module.

## Test plan
- FIPS-197 forward vector, `LANES`=1, `in_inverse`=0:
  - stimulus `in_state`=0x000102030405060708090a0b0c0d0e0f
  - required `out_state`=0x00050a0f04090e03080d02070c01060b, `PIPE_DEPTH` cycles after acceptance.
- Inverse vector, `in_inverse`=1:
  - stimulus 0x000102…0f → 0x000d0a0704010e0b0805020f0c090603
  - round trip: feeding the forward result through inverse returns 0x000102…0f.
- `LANES`=4, alternating mode each beat, back-to-back with `out_ready`=1:
  - each lane and each beat matches the per-lane reference
  - `out_inverse` tracks the beat; no bubbles; throughput 1/cycle.
- Backpressure, `PIPE_DEPTH`=2:
  - hold `out_ready`=0 while pushing 3 beats → `in_ready` drops after 2 accepts, `occupancy`=2, `out_state` stable.
  - then raise `out_ready` → beats drain in order.
- Simultaneous push/pop at full occupancy → `occupancy` stays `PIPE_DEPTH` and `in_ready` stays 1.
- Assert `rst` with 2 beats in flight:
  - `out_valid`=0, `occupancy`=0, `out_state`=0 immediately (asynchronous)
  - no stale beat appears after release.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES types and the byte-order helpers used by the ShiftRows datapath.
// Byte i of a 128-bit state sits at [127-8i -: 8], column-major (i = row + 4*col).
package aes_pkg;

    localparam int STATE_W = 128;
    localparam int BYTE_W  = 8;

    typedef logic [BYTE_W-1:0] aes_byte_t;
    typedef aes_byte_t aes_state_t [16];

    typedef enum logic {
        SR_FWD = 1'b0,
        SR_INV = 1'b1
    } sr_mode_e;

    function automatic aes_state_t state_to_bytes(input logic [STATE_W-1:0] s);
        aes_state_t b;
        for (int i = 0; i < 16; i++) begin
            b[i] = s[STATE_W-1-BYTE_W*i -: BYTE_W];
        end
        return b;
    endfunction

    function automatic logic [STATE_W-1:0] bytes_to_state(input aes_state_t b);
        logic [STATE_W-1:0] s;
        s = '0;
        for (int i = 0; i < 16; i++) begin
            s[STATE_W-1-BYTE_W*i -: BYTE_W] = b[i];
        end
        return s;
    endfunction

endpackage

// File: rtl/shift_rows_perm.sv
// Combinational ShiftRows / InvShiftRows of one 128-bit lane; zero latency, no flow control.
module shift_rows_perm
    import aes_pkg::*;
(
    input  logic [STATE_W-1:0] lane_in,
    input  logic               inverse,
    output logic [STATE_W-1:0] lane_out
);

    sr_mode_e   mode;
    aes_state_t bytes_in;
    aes_state_t bytes_out;

    assign mode = sr_mode_e'(inverse);

    always_comb begin
        bytes_in  = state_to_bytes(lane_in);
        bytes_out = bytes_in;
        // Row r rotates left by r (forward) or right by r (inverse).
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (mode == SR_INV) begin
                    bytes_out[r + 4*c] = bytes_in[r + 4*((c - r + 4) % 4)];
                end else begin
                    bytes_out[r + 4*c] = bytes_in[r + 4*((c + r) % 4)];
                end
            end
        end
        lane_out = bytes_to_state(bytes_out);
    end

endmodule

// File: rtl/shift_rows_pipe.sv
// Elastic PIPE_DEPTH-stage AES ShiftRows/InvShiftRows over LANES states; latency PIPE_DEPTH cycles.
// Backpressure: bubbles collapse, in_ready is combinational from out_ready through the stage chain.
module shift_rows_pipe
    import aes_pkg::*;
#(
    parameter int LANES      = 1,
    parameter int PIPE_DEPTH = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic                               in_inverse,
    input  logic [LANES*STATE_W-1:0]           in_state,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic                               out_inverse,
    output logic [LANES*STATE_W-1:0]           out_state,
    output logic [$clog2(PIPE_DEPTH+1)-1:0]    occupancy
);

    localparam int DATA_W = LANES * STATE_W;
    localparam int OCC_W  = $clog2(PIPE_DEPTH + 1);
    localparam int LAST   = PIPE_DEPTH - 1;

    logic [DATA_W-1:0]     perm_state;
    logic [PIPE_DEPTH-1:0] stage_vld;
    logic [PIPE_DEPTH-1:0] stage_load;
    logic [PIPE_DEPTH-1:0] stage_inv;
    logic [DATA_W-1:0]     stage_dat [PIPE_DEPTH];
    logic                  down_rdy;
    logic [OCC_W-1:0]      occ_q;
    logic                  in_xfer;
    logic                  out_xfer;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        shift_rows_perm u_perm (
            .lane_in  (in_state[STATE_W*l +: STATE_W]),
            .inverse  (in_inverse),
            .lane_out (perm_state[STATE_W*l +: STATE_W])
        );
    end

    // Walk from the output back: a stage can load if it is empty or its successor can load.
    always_comb begin
        stage_load = '0;
        down_rdy   = out_ready;
        for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
            stage_load[k] = !stage_vld[k] || down_rdy;
            down_rdy      = stage_load[k];
        end
    end

    for (genvar k = 0; k < PIPE_DEPTH; k++) begin : g_stage
        logic              up_vld;
        logic [DATA_W-1:0] up_dat;
        logic              up_inv;
        logic              vld_q;
        logic [DATA_W-1:0] dat_q;
        logic              inv_q;

        if (k == 0) begin : g_head
            assign up_vld = in_valid;
            assign up_dat = perm_state;
            assign up_inv = in_inverse;
        end else begin : g_body
            assign up_vld = stage_vld[k-1];
            assign up_dat = stage_dat[k-1];
            assign up_inv = stage_inv[k-1];
        end

        // Data only moves with a real beat so an emptied stage keeps its last contents.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_q <= 1'b0;
                dat_q <= '0;
                inv_q <= 1'b0;
            end else if (stage_load[k]) begin
                vld_q <= up_vld;
                if (up_vld) begin
                    dat_q <= up_dat;
                    inv_q <= up_inv;
                end
            end
        end

        assign stage_vld[k] = vld_q;
        assign stage_dat[k] = dat_q;
        assign stage_inv[k] = inv_q;
    end

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q <= '0;
        end else begin
            case ({in_xfer, out_xfer})
                2'b10:   occ_q <= occ_q + OCC_W'(1);
                2'b01:   occ_q <= occ_q - OCC_W'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

    assign in_ready    = stage_load[0];
    assign out_valid   = stage_vld[LAST];
    assign out_state   = stage_dat[LAST];
    assign out_inverse = stage_inv[LAST];
    assign occupancy   = occ_q;

endmodule
